// File: rtl/ram_shift_pkg.sv
// Shared constants and elaboration helpers for the RAM-based delay line.
package ram_shift_pkg;

  localparam int unsigned DEF_DSIZE  = 1;
  localparam int unsigned DEF_WDEPTH = 800;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sp_ram_rf.sv
// Single-port synchronous RAM, read-first: dout returns the word held before this edge's write.
module sp_ram_rf
  import ram_shift_pkg::*;
#(
  parameter int unsigned DSIZE = 1,
  parameter int unsigned DEPTH = 800,
  parameter int unsigned AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [DSIZE-1:0] din,
  output logic [DSIZE-1:0] dout
);

  logic [DSIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/ram_based_shift_reg.sv
// Fixed WDEPTH-cycle delay line built as a circular buffer over one read-first RAM.
module ram_based_shift_reg
  import ram_shift_pkg::*;
#(
  parameter int unsigned DSIZE  = DEF_DSIZE,
  parameter int unsigned WDEPTH = DEF_WDEPTH,
  parameter int unsigned ASIZE  = clog2(WDEPTH)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [DSIZE-1:0] Din,
  output logic [DSIZE-1:0] Q
);

  localparam logic [ASIZE-1:0] LastAddr = ASIZE'(WDEPTH - 1);
  localparam logic [ASIZE:0]   FullCnt  = (ASIZE + 1)'(WDEPTH);

  logic [ASIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ASIZE:0]   fill_cnt_q, fill_cnt_d;
  logic             valid_q, valid_d;
  logic             ram_we;
  logic [DSIZE-1:0] ram_dout;

  always_comb begin
    ram_we     = ~Reset;
    wr_ptr_d   = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + ASIZE'(1);
    fill_cnt_d = (fill_cnt_q == FullCnt) ? fill_cnt_q : fill_cnt_q + (ASIZE + 1)'(1);
    // The word read this edge is real data only once every slot has been written since reset.
    valid_d    = (fill_cnt_q == FullCnt);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      valid_q    <= valid_d;
    end
  end

  sp_ram_rf #(
    .DSIZE (DSIZE),
    .DEPTH (WDEPTH),
    .AW    (ASIZE)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (wr_ptr_q),
    .din  (Din),
    .dout (ram_dout)
  );

  // Masking after the RAM register keeps stale or uninitialised contents off Q.
  always_comb begin
    Q = valid_q ? ram_dout : '0;
  end

endmodule

// File: tb/tb_ram_based_shift_reg.sv
// Bench for ram_based_shift_reg: two 800-deep instances checked by a scoreboard, one 5-deep by a table.
module tb_ram_based_shift_reg;

  localparam int unsigned W = 800;

  logic       clk = 1'b0;
  logic       rst_ab;
  logic       din_a, q_a;
  logic [7:0] din_b, q_b;
  logic       rst_c;
  logic [3:0] din_c, q_c;

  always #5 clk = ~clk;

  ram_based_shift_reg #(.DSIZE(1), .WDEPTH(W)) u_a (
    .clk(clk), .Reset(rst_ab), .Din(din_a), .Q(q_a)
  );
  ram_based_shift_reg #(.DSIZE(8), .WDEPTH(W)) u_b (
    .clk(clk), .Reset(rst_ab), .Din(din_b), .Q(q_b)
  );
  ram_based_shift_reg #(.DSIZE(4), .WDEPTH(5)) u_c (
    .clk(clk), .Reset(rst_c), .Din(din_c), .Q(q_c)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst;
    logic [3:0] din;
    logic [3:0] q;
    logic [2:0] ptr;
  } vec_t;
  vec_t vecs[$];

  // Reference model for the 800-deep pair: Din history since the last reset edge.
  logic       hist_a [0:4095];
  logic [7:0] hist_b [0:4095];
  int         n_ab = 0;
  logic [7:0] salt = 8'h00;
  logic       exp_qa [$];
  logic [7:0] exp_qb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic add_vec(input logic rst, input logic [3:0] din, input logic [3:0] q,
                         input logic [2:0] ptr);
    vec_t v;
    v.rst = rst; v.din = din; v.q = q; v.ptr = ptr;
    vecs.push_back(v);
  endtask

  task automatic drive_ab(input logic rst);
    rst_ab = rst;
    if (rst) begin
      din_a = 1'($urandom);
      din_b = 8'($urandom);
      exp_qa.push_back(1'b0);
      exp_qb.push_back(8'h00);
      n_ab = 0;
    end else begin
      din_a = n_ab[0] ^ salt[0];
      din_b = 8'(n_ab) + salt;
      exp_qa.push_back((n_ab >= int'(W)) ? hist_a[n_ab - int'(W)] : 1'b0);
      exp_qb.push_back((n_ab >= int'(W)) ? hist_b[n_ab - int'(W)] : 8'h00);
      hist_a[n_ab] = din_a;
      hist_b[n_ab] = din_b;
      n_ab++;
    end
  endtask

  task automatic sample_ab();
    logic       ea;
    logic [7:0] eb;
    ea = exp_qa.pop_front();
    eb = exp_qb.pop_front();
    check("a_q", 32'(q_a), 32'(ea));
    check("b_q", 32'(q_b), 32'(eb));
    if (rst_ab) begin
      check("a_we_in_reset", 32'(u_a.ram_we), 32'd0);
      check("b_we_in_reset", 32'(u_b.ram_we), 32'd0);
    end
  endtask

  task automatic run_ab(input int cycles, input logic rst);
    for (int i = 0; i < cycles; i++) begin
      drive_ab(rst);
      @(posedge clk);
      #1;
      sample_ab();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_ab = 1'b1;
    din_a  = 1'b0;
    din_b  = 8'h00;
    rst_c  = 1'b1;
    din_c  = 4'h0;

    // 5-deep instance: reset, fill, wrap, then a reset over stale RAM contents.
    add_vec(1'b1, 4'd9, 4'd0, 3'd0);
    add_vec(1'b1, 4'd7, 4'd0, 3'd0);
    for (int k = 0; k < 12; k++) begin
      add_vec(1'b0, 4'(k + 1), (k >= 5) ? 4'(k - 4) : 4'd0, 3'(((k + 1) % 5)));
    end
    add_vec(1'b1, 4'd15, 4'd0, 3'd0);
    add_vec(1'b0, 4'd13, 4'd0, 3'd1);
    add_vec(1'b0, 4'd14, 4'd0, 3'd2);
    add_vec(1'b0, 4'd15, 4'd0, 3'd3);
    add_vec(1'b0, 4'd1,  4'd0, 3'd4);
    add_vec(1'b0, 4'd2,  4'd0, 3'd0);
    add_vec(1'b0, 4'd3,  4'd13, 3'd1);
    add_vec(1'b0, 4'd4,  4'd14, 3'd2);

    foreach (vecs[i]) begin
      drive_ab(1'b1);
      rst_c = vecs[i].rst;
      din_c = vecs[i].din;
      @(posedge clk);
      #1;
      sample_ab();
      check("c_q", 32'(q_c), 32'(vecs[i].q));
      check("c_wr_ptr", 32'(u_c.wr_ptr_q), 32'(vecs[i].ptr));
    end
    rst_c = 1'b1;

    // 800-deep pair: power-on reset, long run across pointer wraps.
    run_ab(10, 1'b1);
    salt = 8'h00;
    run_ab(2000, 1'b0);
    // Single-cycle reset after a full fill, then a partial run.
    run_ab(1, 1'b1);
    salt = 8'h55;
    run_ab(300, 1'b0);
    // Mid-operation reset held 10 cycles, then refill past the delay.
    run_ab(10, 1'b1);
    salt = 8'hA3;
    run_ab(900, 1'b0);
    // Long reset hold with Din changing.
    run_ab(50, 1'b1);
    salt = 8'h3C;
    run_ab(20, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
